load_store_unit: RTL and testbench
==================================

# load_store_unit

Processor-side initiator for the word-addressed data memory port (CLK, WE, A, WD, asynchronous RD). Accepts byte, halfword and word load/store requests from the datapath and turns them into word accesses. Loads are aligned and sign/zero-extended; sub-word stores use read-modify-write. Misaligned requests are flagged. Sits between the MEM stage and the data memory, and stalls the pipeline through READY.

## Interface
- ADDR_WIDTH, 32, width of ADDR and MEM_A
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- REQ  in  1  request valid; sampled only while READY=1
- WR  in  1  1=store, 0=load
- SIZE  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
- SIGNED  in  1  loads only: 1=sign-extend, 0=zero-extend
- ADDR  in  ADDR_WIDTH  byte address
- WDATA  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- READY  out  1  unit idle, can accept REQ this cycle
- DONE  out  1  one-cycle pulse: request completed (or rejected)
- ERR  out  1  one-cycle pulse with DONE: request was misaligned/reserved
- RDATA  out  32  last completed load result, held until the next load completes
- MEM_WE  out  1  memory write enable
- MEM_A  out  ADDR_WIDTH  memory address, always word-aligned ([1:0]=00)
- MEM_WD  out  32  memory write data
- MEM_RD  in  32  memory read data, combinational from MEM_A

## Operation
- Little-endian lanes: byte k=ADDR[1:0] is bits [8k+7:8k]; half h=ADDR[1] is bits [16h+15:16h].
- Misaligned: SIZE=01 with ADDR[0]=1; SIZE=10 with ADDR[1:0]≠00; SIZE=11 always.
- States: IDLE, LOAD, MERGE, STORE.
- IDLE: READY=1. On REQ, latch WR, SIZE, SIGNED, ADDR, WDATA. Then:
  - Misaligned: stay IDLE; DONE=ERR=1 next cycle; no memory access.
  - Load: go to LOAD.
  - Word store: buffer←WDATA; go to STORE.
  - Byte/half store: go to MERGE.
- LOAD: MEM_A=latched word address. At the edge, RDATA←extracted lane extended per SIZE/SIGNED (word passes through); DONE←1; go to IDLE.
- MERGE: MEM_A=word address. At the edge, buffer←MEM_RD with the addressed lane(s) replaced by WDATA[7:0]/[15:0]; go to STORE.
- STORE: MEM_A=word address, MEM_WD=buffer, MEM_WE=1. At the edge, DONE←1; go to IDLE.
- MEM_WE = (state==STORE) && !RST, so a reset cycle never writes memory.
- MEM_A=0 and MEM_WD=0 in IDLE. MEM_WE=0 outside STORE.
- Stores and errors leave RDATA unchanged.
- REQ while READY=0 is ignored; the requester holds it.

## Timing
- Reset (synchronous, RST high at an edge): state=IDLE, READY=1, DONE=0, ERR=0, RDATA=0, buffer=0, MEM_WE=0, MEM_A=0, MEM_WD=0. Reset wins over any in-flight state, including STORE; the aborted request produces no DONE.
- Latency counts from the accepting edge E0 to the cycle DONE is high:
  - Load: LOAD in cycle 1; DONE and new RDATA in cycle 2.
  - Word store: STORE in cycle 1 (single MEM_WE cycle); DONE in cycle 2.
  - Sub-word store: MERGE cycle 1, STORE cycle 2; DONE in cycle 3.
  - Misaligned: DONE=ERR=1 in cycle 1.
- DONE cycle is an IDLE cycle (READY=1), so a new REQ can be accepted in the same cycle DONE is high. Back-to-back throughput: one load per 2 cycles.
- MEM_WE is high exactly one cycle per store and never for loads or errors.

## Test plan
- Word store then load: SW ADDR=0x10 WDATA=0xDEADBEEF -> one cycle MEM_WE=1, MEM_A=0x10, MEM_WD=0xDEADBEEF, DONE next cycle. LW 0x10 -> RDATA=0xDEADBEEF two cycles after accept.
- Extension, memory[0x10]=0xDEADBEEF:
  - LB signed 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE.
  - LH signed 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
  - LB signed 0x10 -> 0xFFFFFFEF.
- Read-modify-write on memory[0x10]=0xDEADBEEF:
  - SB 0x11 WDATA=0x123456AA -> MERGE then STORE, MEM_WD=0xDEADAAEF, DONE in cycle 3.
  - Then SH 0x12 WDATA=0x00001234 -> MEM_WD=0x1234AAEF.
- Misaligned: LW 0x11, SH 0x13, SIZE=11 at 0x10 -> each gives DONE=ERR=1 in cycle 1, MEM_WE never high, RDATA and memory unchanged.
- Reset mid-store: RST high during the STORE cycle of SW 0x20 WDATA=0x55AA55AA -> MEM_WE=0, memory[0x20] unchanged, no DONE, RDATA=0, READY=1 next cycle.
- Back-to-back: REQ held with LW 0x10 then SB 0x14 issued in the DONE cycle -> second request accepted on that edge, no idle bubble, both DONE pulses correct.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - datapath-side request/response bus of the load/store unit
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  REQ;
  logic                  WR;
  logic [1:0]            SIZE;
  logic                  SIGNED;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [31:0]           WDATA;
  logic                  READY;
  logic                  DONE;
  logic                  ERR;
  logic [31:0]           RDATA;

  modport master (
    output REQ, WR, SIZE, SIGNED, ADDR, WDATA,
    input  READY, DONE, ERR, RDATA
  );

  modport slave (
    input  REQ, WR, SIZE, SIGNED, ADDR, WDATA,
    output READY, DONE, ERR, RDATA
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store initiator for a word-addressed memory
// Sub-word stores read the word, merge the lane(s), then write the whole word back.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  load_store_unit_if.slave      bus,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_A,
  output logic [31:0]           MEM_WD,
  input  logic [31:0]           MEM_RD
);
  typedef enum logic [1:0] {IDLE, LOAD, MERGE, STORE} state_t;

  state_t                state;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic [31:0]           buffer;
  logic [31:0]           rdata_q;
  logic                  done_q;
  logic                  err_q;

  logic                  misaligned;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [31:0]           load_val;
  logic [31:0]           merge_val;

  always_comb begin
    misaligned = 1'b0;
    case (bus.SIZE)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.ADDR[0];
      2'b10:   misaligned = |bus.ADDR[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Lane extraction and merge both work on the word currently on MEM_RD.
  always_comb begin
    lane_b    = MEM_RD[{addr_q[1:0], 3'b000} +: 8];
    lane_h    = MEM_RD[{addr_q[1], 4'b0000} +: 16];
    load_val  = MEM_RD;
    case (size_q)
      2'b00:   load_val = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_val = MEM_RD;
    endcase
    merge_val = MEM_RD;
    if (size_q == 2'b00)
      merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 16'h0000;
      buffer   <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.REQ) begin
            size_q   <= bus.SIZE;
            signed_q <= bus.SIGNED;
            addr_q   <= bus.ADDR;
            wdata_q  <= bus.WDATA[15:0];
            if (misaligned) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (!bus.WR) begin
              state <= LOAD;
            end else if (bus.SIZE == 2'b10) begin
              buffer <= bus.WDATA;
              state  <= STORE;
            end else begin
              state <= MERGE;
            end
          end
        end
        LOAD: begin
          rdata_q <= load_val;
          done_q  <= 1'b1;
          state   <= IDLE;
        end
        MERGE: begin
          buffer <= merge_val;
          state  <= STORE;
        end
        STORE: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write enable is gated by RST so a reset landing on STORE never writes.
  assign MEM_WE    = (state == STORE) && !RST;
  assign MEM_A     = (state == IDLE) ? '0 : {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign MEM_WD    = (state == STORE) ? buffer : 32'h0000_0000;
  assign bus.READY = (state == IDLE);
  assign bus.DONE  = done_q;
  assign bus.ERR   = err_q;
  assign bus.RDATA = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized checks of load_store_unit against a word-memory model
module tb_load_store_unit;
  logic        CLK = 1'b0;
  logic        RST;
  logic        MEM_WE;
  logic [31:0] MEM_A;
  logic [31:0] MEM_WD;
  logic [31:0] MEM_RD;

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .bus    (bus),
    .MEM_WE (MEM_WE),
    .MEM_A  (MEM_A),
    .MEM_WD (MEM_WD),
    .MEM_RD (MEM_RD)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem     [64];
  logic [31:0] seed    [64];
  logic [31:0] ref_mem [64];
  logic        load_mem;

  always @(posedge CLK) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed[i];
    end else if (MEM_WE) begin
      mem[MEM_A[7:2]] <= MEM_WD;
    end
  end
  assign MEM_RD = mem[MEM_A[7:2]];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rdata;
  logic [31:0] last_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_mis(input logic [1:0] size, input logic [7:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn, input logic [7:0] addr);
    logic [31:0] w, v;
    int idx, k;
    idx = int'(addr) / 4;
    k   = int'(addr) % 4;
    w   = ref_mem[idx];
    if (size == 2'd0) begin
      v = (w >> (8 * k)) & 32'h0000_00FF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * (k / 2))) & 32'h0000_FFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [1:0] size, input logic [7:0] addr, input logic [31:0] wdata);
    logic [31:0] w, mask;
    int idx, k;
    idx = int'(addr) / 4;
    k   = int'(addr) % 4;
    w   = ref_mem[idx];
    if (size == 2'd0) begin
      mask = 32'h0000_00FF << (8 * k);
      return (w & ~mask) | ((wdata & 32'h0000_00FF) << (8 * k));
    end else if (size == 2'd1) begin
      mask = 32'h0000_FFFF << (16 * (k / 2));
      return (w & ~mask) | ((wdata & 32'h0000_FFFF) << (16 * (k / 2)));
    end
    return wdata;
  endfunction

  // Issues one request and checks every cycle until its DONE; with hold, REQ stays high while busy.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [7:0] addr, input logic [31:0] wdata, input logic hold);
    int          lat, we_cyc, waited;
    logic        mis;
    logic [31:0] exp_wd, word_a;
    waited = 0;
    while (bus.READY !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    chk({tag, "_ready"}, 32'(bus.READY), 32'd1);
    mis    = is_mis(size, addr);
    word_a = {24'h0, addr[7:2], 2'b00};
    lat    = mis ? 1 : (!wr ? 2 : (size == 2'd2 ? 2 : 3));
    we_cyc = (wr && !mis) ? lat - 1 : 0;
    exp_wd = (wr && !mis) ? ref_store(size, addr, wdata) : 32'h0;
    if (!wr && !mis) exp_rdata = ref_load(size, sgn, addr);
    bus.REQ    = 1'b1;
    bus.WR     = wr;
    bus.SIZE   = size;
    bus.SIGNED = sgn;
    bus.ADDR   = {24'h0, addr};
    bus.WDATA  = wdata;
    @(posedge CLK);
    if (!hold) #1 bus.REQ = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge CLK);
      chk({tag, "_done"}, 32'(bus.DONE), 32'(c == lat));
      chk({tag, "_we"}, 32'(MEM_WE), 32'(c == we_cyc));
      if (c == 1) chk({tag, "_mem_a"}, MEM_A, mis ? 32'h0 : word_a);
      if (c == we_cyc) begin
        chk({tag, "_wr_a"}, MEM_A, word_a);
        chk({tag, "_wd"}, MEM_WD, exp_wd);
        last_wd = MEM_WD;
      end
      if (c == lat) begin
        chk({tag, "_err"}, 32'(bus.ERR), 32'(mis));
        chk({tag, "_rdata"}, bus.RDATA, exp_rdata);
        chk({tag, "_ready_done"}, 32'(bus.READY), 32'd1);
      end
    end
    if (wr && !mis) ref_mem[int'(addr) / 4] = exp_wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    RST        = 1'b1;
    load_mem   = 1'b1;
    bus.REQ    = 1'b0;
    bus.WR     = 1'b0;
    bus.SIZE   = 2'b00;
    bus.SIGNED = 1'b0;
    bus.ADDR   = 32'h0;
    bus.WDATA  = 32'h0;
    exp_rdata  = 32'h0;
    last_wd    = 32'h0;
    for (int i = 0; i < 64; i++) begin
      w          = $urandom;
      seed[i]    = w;
      ref_mem[i] = w;
    end
    repeat (2) @(posedge CLK);
    #1;
    RST      = 1'b0;
    load_mem = 1'b0;
    @(negedge CLK);
    chk("rst_ready", 32'(bus.READY), 32'd1);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    chk("rst_err", 32'(bus.ERR), 32'd0);
    chk("rst_rdata", bus.RDATA, 32'h0);
    chk("rst_we", 32'(MEM_WE), 32'd0);
    chk("rst_mem_a", MEM_A, 32'h0);
    chk("rst_mem_wd", MEM_WD, 32'h0);

    run_req("sw_10", 1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0);
    chk("sw_10_wd_const", last_wd, 32'hDEADBEEF);
    run_req("lw_10", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 1'b0);
    chk("lw_10_const", bus.RDATA, 32'hDEADBEEF);
    run_req("lb_13", 1'b0, 2'd0, 1'b1, 8'h13, 32'h0, 1'b0);
    chk("lb_13_const", bus.RDATA, 32'hFFFFFFDE);
    run_req("lbu_13", 1'b0, 2'd0, 1'b0, 8'h13, 32'h0, 1'b0);
    chk("lbu_13_const", bus.RDATA, 32'h000000DE);
    run_req("lh_12", 1'b0, 2'd1, 1'b1, 8'h12, 32'h0, 1'b0);
    chk("lh_12_const", bus.RDATA, 32'hFFFFDEAD);
    run_req("lhu_10", 1'b0, 2'd1, 1'b0, 8'h10, 32'h0, 1'b0);
    chk("lhu_10_const", bus.RDATA, 32'h0000BEEF);
    run_req("lb_10", 1'b0, 2'd0, 1'b1, 8'h10, 32'h0, 1'b0);
    chk("lb_10_const", bus.RDATA, 32'hFFFFFFEF);
    run_req("sb_11", 1'b1, 2'd0, 1'b0, 8'h11, 32'h123456AA, 1'b0);
    chk("sb_11_wd_const", last_wd, 32'hDEADAAEF);
    run_req("sh_12", 1'b1, 2'd1, 1'b0, 8'h12, 32'h00001234, 1'b0);
    chk("sh_12_wd_const", last_wd, 32'h1234AAEF);

    run_req("mis_lw_11", 1'b0, 2'd2, 1'b0, 8'h11, 32'h0, 1'b0);
    run_req("mis_sh_13", 1'b1, 2'd1, 1'b0, 8'h13, 32'hCAFEF00D, 1'b0);
    run_req("mis_rsv_10", 1'b0, 2'd3, 1'b1, 8'h10, 32'h0, 1'b0);
    chk("mis_mem_10", mem[4], 32'h1234AAEF);

    // Reset lands on the STORE cycle of a word store.
    bus.REQ   = 1'b1;
    bus.WR    = 1'b1;
    bus.SIZE  = 2'd2;
    bus.ADDR  = 32'h20;
    bus.WDATA = 32'h55AA55AA;
    @(posedge CLK);
    #1;
    bus.REQ = 1'b0;
    RST     = 1'b1;
    @(negedge CLK);
    chk("rst_store_we", 32'(MEM_WE), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_rdata = 32'h0;
    @(negedge CLK);
    chk("rst_store_done", 32'(bus.DONE), 32'd0);
    chk("rst_store_ready", 32'(bus.READY), 32'd1);
    chk("rst_store_rdata", bus.RDATA, 32'h0);
    chk("rst_store_mem", mem[8], ref_mem[8]);

    run_req("b2b_lw", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 1'b1);
    run_req("b2b_sb", 1'b1, 2'd0, 1'b0, 8'h14, 32'h000000C3, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] sz;
      int         pick;
      pick = $urandom_range(0, 9);
      sz   = (pick < 3) ? 2'd0 : (pick < 6) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
      run_req("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), $urandom, 1'b0);
    end

    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
